control_unit: RTL and testbench

Hardwired control sequencer for the single-bus CPU datapath. Each instruction runs through fetch (T0–T2), decode and execute (T3–T5/T6). The sequencer drives every bus-enable, register-load, ALU-select and memory-read strobe that the datapath exposes. It stretches the fetch read with a memory-ready handshake, and it halts on `halt` or on an illegal opcode.

---
 rtl/control_unit.sv | 178 +++++++++++++++++
 tb/tb_control_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Hardwired fetch/decode/execute sequencer for the single-bus
//                CPU datapath. Stretches the fetch read with mem_ready and
//                halts on the halt opcode or on any illegal opcode.
//                Optional feature macro: CU_MULDIV_EN (mul/div with T6).
//  Revision    : 1.0 - initial release
// ============================================================================
module control_unit #(
    parameter int OPW = 5
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [31:0]    ir,
    input  logic           mem_ready,
    output logic           PCout,
    output logic           IncPC,
    output logic           Zin,
    output logic           MARin,
    output logic           PCin,
    output logic           Zlowout,
    output logic           Zhighout,
    output logic           Read,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Yin,
    output logic           LOin,
    output logic           HIin,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic [OPW-1:0] alu_op,
    output logic           run
);

    localparam logic [OPW-1:0] OP_ADD = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_ROL = OPW'(5'b01010);
    localparam logic [OPW-1:0] OP_NEG = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_NOT = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_MUL = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_DIV = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_NOP = OPW'(5'b11010);

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T1W  = 4'd3,
        S_T2   = 4'd4,
        S_T3   = 4'd5,
        S_T4   = 4'd6,
        S_T5   = 4'd7,
        S_T6   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    state_t         state_q, state_d;
    // Low while clear is held and for no cycle afterwards: keeps every output
    // (including run) at 0 during reset, while RST itself shows run=1.
    logic           live_q;
    logic [OPW-1:0] op;
    logic           is_bin, is_un, is_md, is_nop;
    logic           unused_ir;

    assign op        = ir[31 -: OPW];
    assign unused_ir = ^ir[31-OPW:0];

    // Opcode classification; only meaningful from T3 onward.
    always_comb begin
        is_bin = (op >= OP_ADD) && (op <= OP_ROL);
        is_un  = (op == OP_NEG) || (op == OP_NOT);
        is_nop = (op == OP_NOP);
`ifdef CU_MULDIV_EN
        is_md  = (op == OP_MUL) || (op == OP_DIV);
`else
        is_md  = 1'b0;
`endif
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:   state_d = live_q ? S_T0 : S_RST;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = mem_ready ? S_T2 : S_T1W;
            S_T1W:   state_d = mem_ready ? S_T2 : S_T1W;
            S_T2:    state_d = S_T3;
            S_T3: begin
                if (is_bin || is_un || is_md) state_d = S_T4;
                else if (is_nop)              state_d = S_T0;
                else                          state_d = S_HALT;
            end
            S_T4:    state_d = S_T5;
            S_T5:    state_d = is_md ? S_T6 : S_T0;
            S_T6:    state_d = S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_RST;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    // Moore strobe decode from the state register and the opcode field.
    always_comb begin
        PCout = 1'b0; IncPC = 1'b0; Zin = 1'b0; MARin = 1'b0; PCin = 1'b0;
        Zlowout = 1'b0; Zhighout = 1'b0; Read = 1'b0; MDRin = 1'b0;
        MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; LOin = 1'b0; HIin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        alu_op = '0;
        run = 1'b0;
        if (live_q) begin
            run = (state_q != S_HALT);
            case (state_q)
                S_T0: begin
                    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                end
                S_T1: begin
                    Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                end
                S_T1W: begin
                    Read = 1'b1; MDRin = 1'b1;
                end
                S_T2: begin
                    MDRout = 1'b1; IRin = 1'b1;
                end
                S_T3: begin
                    if (is_bin || is_un) begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end else if (is_md) begin
                        Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                end
                S_T4: begin
                    alu_op = op;
                    Zin    = 1'b1;
                    if (is_bin) begin
                        Grc = 1'b1; Rout = 1'b1;
                    end else if (is_md) begin
                        Grb = 1'b1; Rout = 1'b1;
                    end
                end
                S_T5: begin
                    if (is_bin || is_un) begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
`ifdef CU_MULDIV_EN
                    else if (is_md) begin
                        Zlowout = 1'b1; LOin = 1'b1;
                    end
`endif
                end
                S_T6: begin
`ifdef CU_MULDIV_EN
                    Zhighout = 1'b1; HIin = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Self-checking bench for control_unit. A sequence-level model
//                lists the expected strobe word for every cycle of an
//                instruction; random and directed instructions are compared
//                cycle by cycle. Honours CU_MULDIV_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

`ifdef CU_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    // Strobe word layout: {14 datapath strobes, 5 register controls, run, alu_op}
    localparam logic [24:0] PCOUT  = 25'h1 << 24;
    localparam logic [24:0] INCPC  = 25'h1 << 23;
    localparam logic [24:0] ZIN    = 25'h1 << 22;
    localparam logic [24:0] MARIN  = 25'h1 << 21;
    localparam logic [24:0] PCIN   = 25'h1 << 20;
    localparam logic [24:0] ZLOW   = 25'h1 << 19;
    localparam logic [24:0] ZHIGH  = 25'h1 << 18;
    localparam logic [24:0] READ   = 25'h1 << 17;
    localparam logic [24:0] MDRIN  = 25'h1 << 16;
    localparam logic [24:0] MDROUT = 25'h1 << 15;
    localparam logic [24:0] IRIN   = 25'h1 << 14;
    localparam logic [24:0] YIN    = 25'h1 << 13;
    localparam logic [24:0] LOIN   = 25'h1 << 12;
    localparam logic [24:0] HIIN   = 25'h1 << 11;
    localparam logic [24:0] GRA    = 25'h1 << 10;
    localparam logic [24:0] GRB    = 25'h1 << 9;
    localparam logic [24:0] GRC    = 25'h1 << 8;
    localparam logic [24:0] RIN    = 25'h1 << 7;
    localparam logic [24:0] ROUT   = 25'h1 << 6;
    localparam logic [24:0] RUN    = 25'h1 << 5;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        mem_ready = 1'b0;
    logic [31:0] ir = 32'h0;
    logic PCout, IncPC, Zin, MARin, PCin, Zlowout, Zhighout, Read, MDRin;
    logic MDRout, IRin, Yin, LOin, HIin, Gra, Grb, Grc, Rin, Rout, run;
    logic [4:0]  alu_op;
    logic [24:0] obs;

    int total = 0;
    int bad   = 0;

    logic [24:0] exp_q[$];
    bit          mr_q[$];

    control_unit #(.OPW(5)) dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .IncPC(IncPC), .Zin(Zin), .MARin(MARin), .PCin(PCin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .LOin(LOin), .HIin(HIin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .run(run)
    );

    assign obs = {PCout, IncPC, Zin, MARin, PCin, Zlowout, Zhighout, Read,
                  MDRin, MDRout, IRin, Yin, LOin, HIin, Gra, Grb, Grc, Rin,
                  Rout, run, alu_op};

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input logic [24:0] e, input string tag);
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // Expected per-cycle strobes (and the mem_ready to drive in that cycle)
    // for one instruction, written straight from the instruction-class rules.
    function automatic bit build(input logic [4:0] op, input int waits);
        bit bin, un, md, nop;
        logic [24:0] aw;
        bin = (op >= 5'd3) && (op <= 5'd10);
        un  = (op == 5'd16) || (op == 5'd17);
        md  = MD_EN && ((op == 5'd14) || (op == 5'd15));
        nop = (op == 5'd26);
        aw  = 25'(op);
        exp_q.delete();
        mr_q.delete();
        exp_q.push_back(PCOUT | MARIN | INCPC | ZIN | RUN); mr_q.push_back(1'($urandom));
        exp_q.push_back(ZLOW | PCIN | READ | MDRIN | RUN);  mr_q.push_back(waits == 0);
        for (int i = 0; i < waits; i++) begin
            exp_q.push_back(READ | MDRIN | RUN);            mr_q.push_back(i == waits - 1);
        end
        exp_q.push_back(MDROUT | IRIN | RUN);               mr_q.push_back(1'($urandom));
        if (bin || un)   exp_q.push_back(GRB | ROUT | YIN | RUN);
        else if (md)     exp_q.push_back(GRA | ROUT | YIN | RUN);
        else             exp_q.push_back(RUN);
        mr_q.push_back(1'($urandom));
        if (!(bin || un || md)) return !nop;
        if (bin)         exp_q.push_back(GRC | ROUT | ZIN | RUN | aw);
        else if (un)     exp_q.push_back(ZIN | RUN | aw);
        else             exp_q.push_back(GRB | ROUT | ZIN | RUN | aw);
        mr_q.push_back(1'($urandom));
        if (md) begin
            exp_q.push_back(ZLOW | LOIN | RUN);              mr_q.push_back(1'($urandom));
            exp_q.push_back(ZHIGH | HIIN | RUN);             mr_q.push_back(1'($urandom));
        end else begin
            exp_q.push_back(ZLOW | GRA | RIN | RUN);         mr_q.push_back(1'($urandom));
        end
        return 1'b0;
    endfunction

    // Called at a falling edge: clear low for 3 cycles, then one RST cycle.
    task automatic do_reset();
        clear = 1'b0;
        #1;
        check(25'h0, "reset_immediate");
        repeat (3) begin
            @(negedge clock);
            check(25'h0, "reset_held");
        end
        clear = 1'b1;
        @(negedge clock);
        check(RUN, "rst_state");
    endtask

    // Runs one instruction from T0; abort_at >= 0 pulses clear in that cycle.
    task automatic run_instr(input logic [4:0] op, input logic [26:0] fld,
                             input int waits, input int abort_at);
        bit halts;
        int pcin_cnt;
        halts    = build(op, waits);
        pcin_cnt = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            check(exp_q[i], $sformatf("op%02h_w%0d_cyc%0d", op, waits, i));
            if ((obs & PCIN) != 25'h0) pcin_cnt++;
            if (i == 0) ir = {op, fld};
            if (i == abort_at) begin
                do_reset();
                return;
            end
            mem_ready = mr_q[i];
        end
        total++;
        assert (pcin_cnt === 1) else begin
            bad++;
            $error("FAIL pcin_once_op%02h observed=%0d expected=1", op, pcin_cnt);
        end
        if (halts) begin
            repeat (12) begin
                @(negedge clock);
                check(25'h0, $sformatf("halted_op%02h", op));
            end
            do_reset();
        end
    endtask

    initial begin
        logic [4:0] legal [13];
        legal = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                  5'd16, 5'd17, 5'd14, 5'd15, 5'd26};
        #2;
        @(negedge clock);
        do_reset();
        // and r2, r3, r0 with zero-wait memory
        run_instr(5'b00101, 27'h1180000, 0, -1);
        // memory wait of 3 cycles on an add
        run_instr(5'b00011, 27'($urandom), 3, -1);
        // mul: full T6 sequence when enabled, HALT otherwise
        run_instr(5'b01110, 27'($urandom), 0, -1);
        run_instr(5'b01111, 27'($urandom), 2, -1);
        run_instr(5'b11010, 27'($urandom), 0, -1);
        run_instr(5'b10000, 27'($urandom), 1, -1);
        run_instr(5'b10001, 27'($urandom), 0, -1);
        // random legal instruction stream
        for (int n = 0; n < 25; n++) begin
            run_instr(legal[$urandom_range(0, 12)], 27'($urandom),
                      int'($urandom_range(0, 3)), -1);
        end
        // illegal opcode, then explicit halt
        run_instr(5'b11111, 27'($urandom), 0, -1);
        run_instr(5'b00000, 27'($urandom), 1, -1);
        run_instr(5'b11011, 27'($urandom), 0, -1);
        // clear pulsed during T4 of an add: no T5 ever appears
        run_instr(5'b00011, 27'($urandom), 0, 4);
        run_instr(5'b00100, 27'($urandom), 2, 6);
        run_instr(5'b00110, 27'($urandom), 0, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
